// File: rtl/tag_frame_gen.sv
// rtl/tag_frame_gen.sv - tag-backscatter frame source: junk, preamble, FM0 data, zero tail
module tag_frame_gen #(
  parameter int                      PREAMBLE_LEN = 80,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE     = 80'hFFF07C03F0003FF,
  parameter int                      CNT_W        = 16,
  parameter int                      SYM_W        = 4,
  parameter logic [15:0]             LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_junk_len,
  input  logic [CNT_W-1:0] cfg_data_bits,
  input  logic [CNT_W-1:0] cfg_zero_len,
  input  logic [SYM_W-1:0] cfg_sym_period,
  input  logic [7:0]       cfg_flip_thresh,
  input  logic             cfg_loop,
  output logic             out_sample,
  output logic [1:0]       out_phase,
  output logic             exp_bit,
  output logic             exp_vld,
  output logic             busy,
  output logic             done
);

  localparam int PW = $clog2(PREAMBLE_LEN);

  typedef enum logic [2:0] {S_IDLE, S_JUNK, S_PREA, S_DATA, S_ZERO} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             level_q, level_d;
  logic             bit_q, bit_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] junk_len_q, junk_len_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] zero_len_q, zero_len_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [7:0]       thresh_q, thresh_d;
  logic             loop_q, loop_d;
  logic             out_sample_q, out_sample_d;
  logic [1:0]       out_phase_q, out_phase_d;
  logic             exp_bit_q, exp_bit_d;
  logic             exp_vld_q, exp_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  state_e           nxt;
  logic             enter;
  logic             frame_end;
  logic             relatch;
  logic             dummy;
  logic             cur_bit;
  logic [PW-1:0]    prea_idx;

  // Next-state logic: decide the phase for this strobe, then emit its sample.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sym_cnt_d    = sym_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    level_d      = level_q;
    bit_d        = bit_q;
    lfsr_d       = lfsr_q;
    junk_len_d   = junk_len_q;
    bits_d       = bits_q;
    zero_len_d   = zero_len_q;
    sym_d        = sym_q;
    thresh_d     = thresh_q;
    loop_d       = loop_q;
    out_sample_d = out_sample_q;
    out_phase_d  = out_phase_q;
    exp_bit_d    = exp_bit_q;
    exp_vld_d    = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    nxt          = state_q;
    enter        = 1'b0;
    frame_end    = 1'b0;
    relatch      = 1'b0;
    dummy        = 1'b0;
    cur_bit      = 1'b0;
    prea_idx     = '0;

    if (strobe) begin
      case (state_q)
        S_IDLE: if (start) relatch = 1'b1;
        S_JUNK: begin
          if (cnt_q == junk_len_q - 1'b1) begin
            nxt   = S_PREA;
            enter = 1'b1;
          end
        end
        S_PREA: begin
          if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            enter = 1'b1;
            if (bits_q != '0)          nxt = S_DATA;
            else if (zero_len_q != '0) nxt = S_ZERO;
            else                       frame_end = 1'b1;
          end
        end
        S_DATA: begin
          // Last sample of the trailing dummy symbol ends the phase.
          if (bit_cnt_q == bits_q && sym_cnt_q == sym_q - 1'b1) begin
            enter = 1'b1;
            if (zero_len_q != '0) nxt = S_ZERO;
            else                  frame_end = 1'b1;
          end
        end
        S_ZERO: if (cnt_q == zero_len_q - 1'b1) frame_end = 1'b1;
        default: nxt = S_IDLE;
      endcase

      if (frame_end) begin
        if (loop_q) relatch = 1'b1;
        else        nxt = S_IDLE;
      end

      if (relatch) begin
        junk_len_d = cfg_junk_len;
        bits_d     = cfg_data_bits;
        zero_len_d = cfg_zero_len;
        sym_d      = (cfg_sym_period < SYM_W'(2)) ? SYM_W'(2) : cfg_sym_period;
        thresh_d   = cfg_flip_thresh;
        loop_d     = cfg_loop;
        enter      = 1'b1;
        nxt        = (cfg_junk_len != '0) ? S_JUNK : S_PREA;
      end

      state_d = nxt;
      if (nxt == S_IDLE) begin
        busy_d       = 1'b0;
        done_d       = (state_q != S_IDLE);
        out_sample_d = 1'b0;
        out_phase_d  = 2'd3;
      end else begin
        busy_d = 1'b1;
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        cnt_d  = enter ? '0 : cnt_q + 1'b1;
        case (nxt)
          S_JUNK: begin
            out_sample_d = lfsr_q[0];
            out_phase_d  = 2'd0;
          end
          S_PREA: begin
            prea_idx     = PW'(PREAMBLE_LEN - 1) - cnt_d[PW-1:0];
            out_sample_d = PREAMBLE[prea_idx];
            out_phase_d  = 2'd1;
          end
          S_DATA: begin
            if (enter || sym_cnt_q == sym_q - 1'b1) begin
              // Symbol boundary: FM0 always toggles here; level starts from 0 on entry.
              sym_cnt_d = '0;
              bit_cnt_d = enter ? '0 : bit_cnt_q + 1'b1;
              dummy     = (bit_cnt_d == bits_q);
              cur_bit   = dummy ? 1'b1 : lfsr_q[1];
              bit_d     = cur_bit;
              level_d   = enter ? 1'b1 : ~level_q;
              if (!dummy) begin
                exp_bit_d = cur_bit;
                exp_vld_d = 1'b1;
              end
            end else begin
              // A 0 bit gets the extra mid-symbol transition.
              sym_cnt_d = sym_cnt_q + 1'b1;
              if (!bit_q && sym_cnt_d == (sym_q >> 1)) level_d = ~level_q;
            end
            out_sample_d = level_d ^ (lfsr_q[15:8] < thresh_q);
            out_phase_d  = 2'd2;
          end
          default: begin
            out_sample_d = 1'b0;
            out_phase_d  = 2'd3;
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sym_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      level_q      <= 1'b0;
      bit_q        <= 1'b0;
      lfsr_q       <= LFSR_SEED;
      junk_len_q   <= '0;
      bits_q       <= '0;
      zero_len_q   <= '0;
      sym_q        <= '0;
      thresh_q     <= '0;
      loop_q       <= 1'b0;
      out_sample_q <= 1'b0;
      out_phase_q  <= 2'd3;
      exp_bit_q    <= 1'b0;
      exp_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      level_q      <= level_d;
      bit_q        <= bit_d;
      lfsr_q       <= lfsr_d;
      junk_len_q   <= junk_len_d;
      bits_q       <= bits_d;
      zero_len_q   <= zero_len_d;
      sym_q        <= sym_d;
      thresh_q     <= thresh_d;
      loop_q       <= loop_d;
      out_sample_q <= out_sample_d;
      out_phase_q  <= out_phase_d;
      exp_bit_q    <= exp_bit_d;
      exp_vld_q    <= exp_vld_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign out_sample = out_sample_q;
  assign out_phase  = out_phase_q;
  assign exp_bit    = exp_bit_q;
  assign exp_vld    = exp_vld_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tag_frame_gen.sv
// tb/tb_tag_frame_gen.sv - scoreboard bench for tag_frame_gen against a frame-level model
module tb_tag_frame_gen;

  localparam logic [79:0] PRE  = 80'hFFF07C03F0003FF;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_junk_len = '0;
  logic [15:0] cfg_data_bits = '0;
  logic [15:0] cfg_zero_len = '0;
  logic [3:0]  cfg_sym_period = 4'd2;
  logic [7:0]  cfg_flip_thresh = '0;
  logic        cfg_loop = 1'b0;
  logic        out_sample;
  logic [1:0]  out_phase;
  logic        exp_bit;
  logic        exp_vld;
  logic        busy;
  logic        done;

  tag_frame_gen dut (
    .clk(clk), .rst_n(rst_n), .strobe(strobe), .start(start),
    .cfg_junk_len(cfg_junk_len), .cfg_data_bits(cfg_data_bits),
    .cfg_zero_len(cfg_zero_len), .cfg_sym_period(cfg_sym_period),
    .cfg_flip_thresh(cfg_flip_thresh), .cfg_loop(cfg_loop),
    .out_sample(out_sample), .out_phase(out_phase), .exp_bit(exp_bit),
    .exp_vld(exp_vld), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int stb_mode = 0;
  int cyc = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  int pop_cnt = 0;
  int busy_cyc = 0;
  logic [2:0]  sq[$];
  bit          eq[$];
  logic [15:0] m_lfsr = SEED;
  logic [2:0]  mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference model: one frame of samples, one entry per strobe, from the frame rules.
  task automatic model_frame(input int junk, input int bits, input int symr, input int zero,
                             input int thr, output int n);
    int p;
    bit lvl;
    bit b;
    bit v;
    p = (symr < 2) ? 2 : symr;
    n = 0;
    lvl = 1'b0;
    for (int k = 0; k < junk; k++) begin
      sq.push_back({2'd0, m_lfsr[0]}); m_lfsr = step(m_lfsr); n++;
    end
    for (int k = 0; k < 80; k++) begin
      sq.push_back({2'd1, PRE[79-k]}); m_lfsr = step(m_lfsr); n++;
    end
    if (bits > 0) begin
      for (int s = 0; s <= bits; s++) begin
        b = (s == bits) ? 1'b1 : m_lfsr[1];
        if (s < bits) eq.push_back(b);
        for (int t = 0; t < p; t++) begin
          v = (t < p / 2) ? ~lvl : (b ? ~lvl : lvl);
          v = v ^ (int'(m_lfsr[15:8]) < thr);
          sq.push_back({2'd2, v}); m_lfsr = step(m_lfsr); n++;
        end
        if (b) lvl = ~lvl;
      end
    end
    for (int k = 0; k < zero; k++) begin
      sq.push_back({2'd3, 1'b0}); m_lfsr = step(m_lfsr); n++;
    end
  endtask

  // Monitor and strobe driver: check what the last edge produced, then pick the next strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (!strobe) chk("vld_in_gap", exp_vld, 0);
      if (exp_vld) begin
        vld_cnt++;
        if (eq.size() == 0) fail("exp_bit_unexpected");
        else chk("exp_bit", exp_bit, eq.pop_front());
      end
      if (strobe && busy) begin
        pop_cnt++;
        if (sq.size() == 0) fail("sample_unexpected");
        else begin
          mon_e = sq.pop_front();
          chk("out_sample", out_sample, mon_e[0]);
          chk("out_phase", out_phase, mon_e[2:1]);
        end
      end
    end
    cyc++;
    if (stb_mode == 0)     strobe = 1'b1;
    else if (stb_mode > 0) strobe = (cyc % stb_mode == 0);
    else                   strobe = ($urandom_range(1, 0) == 1);
  end

  task automatic chk_reset();
    chk("rst_out_sample", out_sample, 0);
    chk("rst_out_phase", out_phase, 3);
    chk("rst_exp_bit", exp_bit, 0);
    chk("rst_exp_vld", exp_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    #1 rst_n = 1'b1;
    sq.delete(); eq.delete();
    m_lfsr = SEED;
  endtask

  function automatic int lim_for(input int n);
    int mul;
    mul = (stb_mode == 0) ? 1 : (stb_mode > 0 ? stb_mode : 8);
    return (n + 50) * mul + 200;
  endfunction

  task automatic kick(output bit ok);
    int lim;
    lim = 0;
    start = 1'b1;
    while (!busy && lim < 200) begin @(negedge clk); lim++; end
    #1 start = 1'b0;
    ok = busy;
    if (!ok) fail("start_timeout");
  endtask

  task automatic run_frame(input int junk, input int bits, input int sym, input int zero,
                           input int thr, input int nfr, input bit scramble);
    int n, d0, p0, lim;
    bit ok;
    @(negedge clk); #1;
    cfg_junk_len = 16'(junk); cfg_data_bits = 16'(bits); cfg_zero_len = 16'(zero);
    cfg_sym_period = 4'(sym); cfg_flip_thresh = 8'(thr); cfg_loop = (nfr > 1);
    for (int f = 0; f < nfr; f++) model_frame(junk, bits, sym, zero, thr, n);
    d0 = done_cnt;
    p0 = pop_cnt;
    kick(ok);
    if (scramble) begin
      cfg_junk_len = 16'($urandom_range(40, 0)); cfg_data_bits = 16'($urandom_range(40, 0));
      cfg_zero_len = 16'($urandom_range(40, 0)); cfg_sym_period = 4'($urandom);
      cfg_flip_thresh = 8'($urandom);
    end
    if (nfr > 1) begin
      lim = 0;
      while (pop_cnt - p0 < n + 5 && lim < lim_for(2 * n)) begin @(negedge clk); lim++; end
      #1 cfg_loop = 1'b0;
    end
    lim = 0;
    while (done_cnt == d0 && lim < lim_for(n * nfr)) begin @(negedge clk); lim++; end
    if (done_cnt == d0) fail("done_timeout");
    repeat (3) @(negedge clk);
    chk("done_count", done_cnt - d0, 1);
    chk("samples_left", sq.size(), 0);
    chk("exp_bits_left", eq.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_phase", out_phase, 3);
    sq.delete(); eq.delete();
  endtask

  initial begin
    int b0, v0, d0, n, lim;
    bit ok;
    repeat (3) @(negedge clk);
    chk_reset();
    #1 rst_n = 1'b1;

    // Long one-shot frame, strobe every cycle.
    stb_mode = 0;
    b0 = busy_cyc; v0 = vld_cnt;
    run_frame(200, 2800, 11, 41, 0, 1, 1'b0);
    chk("t1_busy_cycles", busy_cyc - b0, 31132);
    chk("t1_vld_pulses", vld_cnt - v0, 2800);

    // Preamble straight after start, then data.
    run_frame(0, 20, 5, 0, 0, 1, 1'b0);
    // Short FM0 frame and illegal/extreme symbol periods.
    run_frame(3, 4, 4, 2, 0, 1, 1'b0);
    run_frame(2, 6, 0, 1, 0, 1, 1'b0);
    run_frame(1, 3, 15, 0, 0, 1, 1'b0);
    // Data phase skipped.
    run_frame(4, 0, 6, 3, 0, 1, 1'b0);

    // Flip injection: same seed with and without flips.
    do_reset();
    run_frame(10, 64, 8, 5, 0, 1, 1'b0);
    do_reset();
    run_frame(10, 64, 8, 5, 255, 1, 1'b0);

    // Continuous loop, strobe every 3rd clock.
    stb_mode = 3;
    b0 = vld_cnt;
    run_frame(20, 30, 5, 10, 0, 3, 1'b0);
    chk("loop_vld_pulses", vld_cnt - b0, 90);

    // Reset in the middle of DATA, then replay from the seed.
    stb_mode = 0;
    @(negedge clk); #1;
    cfg_junk_len = 16'd5; cfg_data_bits = 16'd150; cfg_zero_len = 16'd4;
    cfg_sym_period = 4'd3; cfg_flip_thresh = 8'd40; cfg_loop = 1'b0;
    model_frame(5, 150, 3, 4, 40, n);
    kick(ok);
    v0 = vld_cnt; lim = 0;
    while (vld_cnt - v0 < 100 && lim < 2000) begin @(negedge clk); lim++; end
    if (vld_cnt - v0 < 100) fail("bit100_timeout");
    d0 = done_cnt;
    do_reset();
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    run_frame(5, 150, 3, 4, 40, 1, 1'b0);

    // Randomised frames, random strobe density, cfg scrambled mid-frame.
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(2, 0))
        0: stb_mode = 0;
        1: stb_mode = 2;
        default: stb_mode = -1;
      endcase
      run_frame($urandom_range(30, 0), $urandom_range(40, 0), $urandom_range(15, 0),
                $urandom_range(20, 0), $urandom_range(255, 0), 1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tag_frame_gen.md
Name: tag_frame_gen

Overview:
- Synthesizable, parametrised tag-backscatter frame source for on-chip loopback and bench stimulus of the RFID receive chain.
- Emits one sample per strobe. Each frame is built from four phases: random junk, a fixed preamble, FM0-encoded random data with optional sample bit-flips, and a zero tail.
- Publishes each encoded data bit on an expected-bit side channel, so a monitor can score the decoder output.
- Supports one-shot and continuous-loop modes, and latches runtime-configurable lengths per frame.

Parameters:
- PREAMBLE_LEN, 80, number of preamble samples.
- PREAMBLE, 80'hFFF07C03F0003FF, preamble pattern; the MSB is sent first.
- CNT_W, 16, width of the length configs and phase counters.
- SYM_W, 4, width of cfg_sym_period.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- strobe  in  1  sample tick; all phase progress happens only on cycles with strobe=1.
- start  in  1  level; sampled in IDLE.
- cfg_junk_len  in  CNT_W  junk samples per frame; 0 skips the junk phase.
- cfg_data_bits  in  CNT_W  data bits per frame; 0 skips the data phase.
- cfg_zero_len  in  CNT_W  zero-tail samples; 0 skips the tail.
- cfg_sym_period  in  SYM_W  samples per FM0 symbol; legal range 2..2^SYM_W-1.
- cfg_flip_thresh  in  8  bit-flip probability; 0 disables flips.
- cfg_loop  in  1  repeat frames while high.
- out_sample  out  1  registered sample stream.
- out_phase  out  2  phase of the sample on out_sample: 0=JUNK, 1=PREA, 2=DATA, 3=ZERO/IDLE.
- exp_bit  out  1  data bit being encoded.
- exp_vld  out  1  one-cycle qualifier for exp_bit.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset values: out_sample=0, out_phase=3, exp_bit=0, exp_vld=0, busy=0, done=0, state=IDLE, lfsr=LFSR_SEED, all counters=0.
- Configuration latch:
  - cfg_* are latched on the cycle that leaves IDLE, and re-latched at every loop restart.
  - Mid-frame changes to cfg_* have no effect.
- LFSR:
  - 16-bit Galois LFSR, polynomial mask 16'hB400, shift right.
  - Advances on every strobe while busy.
  - The seed is restored only by reset, never by start.
- IDLE: on strobe with start=1, go to the first enabled phase in the order JUNK, PREA, DATA, ZERO. PREA is always enabled.
- Phase start and transition timing:
  - The first sample of a phase is emitted on the same strobe that enters it.
  - A phase of length L occupies exactly L strobes.
  - The transition to the next phase takes effect on the strobe after the last sample, with no gap.
- JUNK: out_sample <= lfsr[0].
- PREA: out_sample <= PREAMBLE[PREAMBLE_LEN-1-cnt].
- DATA encoding:
  - Consists of cfg_data_bits symbols, followed by one dummy-1 symbol.
  - The FM0 level register is cleared to 0 on entry to DATA.
  - On sample 0 of each symbol: the level toggles; the data bit is taken from lfsr[1]; exp_bit is set to that bit; exp_vld=1 for that single cycle.
  - For a 0 bit, the level toggles again at sample index cfg_sym_period>>1.
  - The dummy-1 symbol never asserts exp_vld.
  - out_sample <= level XOR flip, where flip = (lfsr[15:8] < cfg_flip_thresh).
- ZERO: out_sample <= 0.
- End of ZERO (or end of DATA when cfg_zero_len=0):
  - If cfg_loop=1, restart at the first enabled phase with no idle strobe.
  - Otherwise enter IDLE, pulse done for one clk, and drop busy in the same cycle.
- Strobe gaps: with strobe=0 all state holds and exp_vld=0.
- start in a busy state is ignored.
- An asynchronous reset mid-frame returns immediately to the reset values; no done pulse is issued.
- Illegal cfg_sym_period values (<2) are treated as 2.

Test Plan:
- One-shot frame, strobe every cycle: junk=200, bits=2800, sym=11, zero=41, flip=0, loop=0.
  - Required: busy for exactly 200 + 80 + 2801*11 + 41 = 31132 strobes.
  - Required: 2800 exp_vld pulses, then one done pulse.
- Preamble fidelity, junk=0: the first 80 samples equal PREAMBLE MSB-first with out_phase=1; the next sample has out_phase=2.
- FM0 check, sym=4, bits=4, LFSR forced to give bits 1,0,1,1:
  - Required out_sample: 1111 0011 0000 1111, then dummy 0000.
  - Required: exp_bit sequence 1,0,1,1.
- Flip injection: flip=255, sym=8.
  - Required: every DATA sample differs from the flip=0 run of the same seed wherever lfsr[15:8]<255.
  - Required: exp_bit is unchanged.
- Loop with strobe every 3rd clk: loop=1 for 3 frames, then drop cfg_loop.
  - Required: no idle strobe between frames; done exactly once.
  - Required: the junk of frames 2 and 3 differs from frame 1.
- Reset mid-DATA (rst_n low for 2 clk at bit 100): all outputs return to reset values; the next start replays the frame from LFSR_SEED.
